// File: rtl/rps2_if.sv
// Request/grant bundle for the rps2 two-way priority arbiter.
// Controls are driven by the master; grants and counters are returned by the slave.
interface rps2_if;
  logic [1:0] req;
  logic       en;
  logic       sel;
  logic [1:0] gnt;
  logic [1:0] gnt_q;
  logic       any_gnt;
  logic [7:0] gnt_cnt0;
  logic [7:0] gnt_cnt1;

  modport master (
    output req, en, sel,
    input  gnt, gnt_q, any_gnt, gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  req, en, sel,
    output gnt, gnt_q, any_gnt, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/rps2.sv
// Two-requester combinational priority arbiter with registered grant copy.
// Define RPS2_GNT_CNT_EN to build the saturating per-requester grant counters.
module rps2 (
  input  logic   clk,
  input  logic   rst_n,
  rps2_if.slave  bus
);

  logic [1:0] gnt_s;
  logic [1:0] gnt_q_r;

  function automatic logic [1:0] arb_fn(input logic [1:0] req_v,
                                        input logic       en_v,
                                        input logic       sel_v);
    logic [1:0] g;
    g = 2'b00;
    if (en_v) begin
      case (req_v)
        2'b00:   g = 2'b00;
        2'b01:   g = 2'b01;
        2'b10:   g = 2'b10;
        2'b11:   g = sel_v ? 2'b10 : 2'b01;
        default: g = 2'b00;
      endcase
    end else begin
      g = 2'b00;
    end
    return g;
  endfunction

  // Grant decode: purely combinational, independent of clock and reset.
  always_comb begin
    gnt_s = arb_fn(bus.req, bus.en, bus.sel);
  end

  assign bus.gnt     = gnt_s;
  assign bus.any_gnt = gnt_s[1] | gnt_s[0];

  // Registered copy of the grant vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q_r <= 2'b00;
    end else begin
      gnt_q_r <= gnt_s;
    end
  end

  assign bus.gnt_q = gnt_q_r;

`ifdef RPS2_GNT_CNT_EN
  logic [7:0] cnt0_r;
  logic [7:0] cnt1_r;

  // Saturating grant counters; they stick at 255 rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= 8'd0;
      cnt1_r <= 8'd0;
    end else begin
      if (gnt_s[0] && (cnt0_r != 8'd255)) begin
        cnt0_r <= cnt0_r + 8'd1;
      end
      if (gnt_s[1] && (cnt1_r != 8'd255)) begin
        cnt1_r <= cnt1_r + 8'd1;
      end
    end
  end

  assign bus.gnt_cnt0 = cnt0_r;
  assign bus.gnt_cnt1 = cnt1_r;
`else
  assign bus.gnt_cnt0 = 8'd0;
  assign bus.gnt_cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_rps2.sv
// Scoreboard bench for rps2: a priority-list reference model predicts each
// cycle's outputs, a monitor pops the predictions after every rising edge.
module tb_rps2;

  logic clk;
  logic rst_n;
  rps2_if bus ();

  rps2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    logic       a;
    logic [1:0] q;
    logic [7:0] c0;
    logic [7:0] c1;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Reference: walk requesters from highest to lowest priority, first asking one wins.
  function automatic logic [1:0] model_gnt(input logic [1:0] r, input logic e, input logic s);
    int order[2];
    model_gnt = 2'b00;
    if (!e) return 2'b00;
    order[0] = s ? 1 : 0;
    order[1] = s ? 0 : 1;
    for (int k = 0; k < 2; k++) begin
      if (r[order[k]]) begin
        model_gnt = 2'b00;
        model_gnt[order[k]] = 1'b1;
        return model_gnt;
      end
    end
  endfunction

  // Apply one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic drive_cycle(input logic [1:0] r, input logic e, input logic s);
    exp_t x;
    logic [1:0] g;
    @(negedge clk);
    bus.req = r;
    bus.en  = e;
    bus.sel = s;
    g = model_gnt(r, e, s);
`ifdef RPS2_GNT_CNT_EN
    if (g[0]) m_cnt0 = (m_cnt0 + 1 > 255) ? 255 : m_cnt0 + 1;
    if (g[1]) m_cnt1 = (m_cnt1 + 1 > 255) ? 255 : m_cnt1 + 1;
`endif
    x.g  = g;
    x.a  = (g != 2'b00);
    x.q  = g;
    x.c0 = m_cnt0[7:0];
    x.c1 = m_cnt1[7:0];
    sb_q.push_back(x);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("gnt",      {30'd0, bus.gnt},   {30'd0, x.g});
        check("any_gnt",  {31'd0, bus.any_gnt}, {31'd0, x.a});
        check("gnt_q",    {30'd0, bus.gnt_q}, {30'd0, x.q});
        check("gnt_cnt0", {24'd0, bus.gnt_cnt0}, {24'd0, x.c0});
        check("gnt_cnt1", {24'd0, bus.gnt_cnt1}, {24'd0, x.c1});
      end
    end
  end

  initial begin
    logic [1:0] sweep;
    rst_n   = 1'b0;
    bus.req = 2'b00;
    bus.en  = 1'b0;
    bus.sel = 1'b0;
    #3;
    check("rst_gnt_q", {30'd0, bus.gnt_q}, 32'd0);
    check("rst_cnt0",  {24'd0, bus.gnt_cnt0}, 32'd0);
    check("rst_cnt1",  {24'd0, bus.gnt_cnt1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sweeps for both priority settings, then the disabled cases.
    for (int s = 1; s >= 0; s--) begin
      for (int r = 0; r < 4; r++) begin
        sweep = r[1:0];
        drive_cycle(sweep, 1'b1, s[0]);
      end
    end
    drive_cycle(2'b01, 1'b0, 1'b0);
    drive_cycle(2'b11, 1'b0, 1'b0);
    drive_cycle(2'b01, 1'b0, 1'b1);
    drive_cycle(2'b11, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      drive_cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset pulsed between edges while requester 1 is granted.
    drive_cycle(2'b10, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt_q", {30'd0, bus.gnt_q}, 32'd0);
    check("midrst_cnt0",  {24'd0, bus.gnt_cnt0}, 32'd0);
    check("midrst_cnt1",  {24'd0, bus.gnt_cnt1}, 32'd0);
    check("midrst_gnt",   {30'd0, bus.gnt}, 32'd2);
    check("midrst_any",   {31'd0, bus.any_gnt}, 32'd1);
    #1;
    rst_n  = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    drive_cycle(2'b10, 1'b1, 1'b0);

    // Long hold on requester 0 drives its counter into saturation.
    for (int i = 0; i < 300; i++) begin
      drive_cycle(2'b01, 1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rps2.md
RPS2 -- requirements
Module: rps2

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, named as the codebase names them.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req  input  2  request vector; bit i = requester i.
REQ-005 en  input  1  global enable; 0 forces every grant to 0.
REQ-006 sel  input  1  priority select; 1 = req[1] high priority, 0 = req[0] high priority.
REQ-007 gnt  output  2  combinational grant, at most one bit set.
REQ-008 gnt_q  output  2  gnt registered on clock.
REQ-009 any_gnt  output  1  combinational OR of gnt.
REQ-010 gnt_cnt0  output  8  grant count for requester 0 (see Configuration).
REQ-011 gnt_cnt1  output  8  grant count for requester 1 (see Configuration).

Function
REQ-012 gnt SHALL be purely combinational from req, en and sel, with zero-cycle latency and no dependence on clock or reset_n.
REQ-013 en=0 -> gnt SHALL be 00 regardless of req and sel.
REQ-014 en=1, req=00 -> gnt SHALL be 00.
REQ-015 en=1, req=01 -> gnt SHALL be 01 for either sel.
REQ-016 en=1, req=10 -> gnt SHALL be 10 for either sel.
REQ-017 en=1, req=11 -> gnt SHALL be 10 when sel=1 and 01 when sel=0.
REQ-018 gnt SHALL never be 11 and SHALL never contain X/Z when the inputs are known.
REQ-019 any_gnt SHALL equal gnt[1] | gnt[0].
REQ-020 gnt_q SHALL load gnt on each rising clock edge while reset_n=1.
REQ-021 A change in sel SHALL affect only the req=11 case and SHALL take effect in the same delta as the input change.

Reset
REQ-022 reset_n=0 SHALL immediately, without waiting for a clock edge, force gnt_q=00, gnt_cnt0=0 and gnt_cnt1=0.
REQ-023 Reset SHALL NOT affect the combinational outputs gnt and any_gnt.
REQ-024 If reset_n is asserted mid-operation, registered state SHALL clear at once; the first capture SHALL occur on the first rising edge after reset_n returns to 1.

Configuration
REQ-025 The macro RPS2_GNT_CNT_EN SHALL control the grant counters.
REQ-026 With RPS2_GNT_CNT_EN defined, gnt_cntN SHALL increment by 1 on each rising edge where gnt[N]=1, and SHALL saturate at 255 without wrapping.
REQ-027 Without RPS2_GNT_CNT_EN, gnt_cnt0 and gnt_cnt1 SHALL be held at constant 0 and no counter registers SHALL be implemented.

Verification
REQ-028 en=1, sel=1, req swept 00/01/10/11 -> gnt = 00/01/10/10.
REQ-029 en=1, sel=0, req swept 00/01/10/11 -> gnt = 00/01/10/01.
REQ-030 en=0, req=01 and then req=11 with either sel -> gnt=00 and any_gnt=0.
REQ-031 reset_n pulsed low between clock edges while gnt=10 -> gnt_q=00 immediately; after release, gnt_q=10 one edge later.
REQ-032 With RPS2_GNT_CNT_EN defined: req=01, en=1 held for 300 cycles -> gnt_cnt0=255 and gnt_cnt1=0.
REQ-033 Without RPS2_GNT_CNT_EN: the REQ-032 stimulus -> both counters read 0.
